mvm_stream_engine: RTL and testbench
====================================

Name: mvm_stream_engine

Overview:
- Parametrised signed matrix-vector multiply engine: y = A·x, with A being KxK and x being Kx1.
- Uses P parallel MAC lanes, so K rows are processed in K/P row groups.
- Operands stream in, and results stream out, over valid/ready handshakes.
- A stays resident across runs, so new vectors can be loaded and multiplied without reloading the matrix.
- Sits between the host load interface and downstream consumers; it is the streaming, back-pressurable successor to the fixed-lane mvm datapath/control pair.

Parameters:
- K, 8, matrix/vector dimension; K >= 2; K must be a multiple of P.
- P, 4, parallel MAC lanes; 1 <= P <= K.
- B, 16, signed operand width.
- G, 1, extra product pipeline register; 0 = none, 1 = one.
- ACC_W, 2*B+$clog2(K), accumulator and result width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load_matrix  in  1  one-cycle command: next K*K input beats are A, row-major.
- load_vector  in  1  one-cycle command: next K input beats are x.
- start  in  1  one-cycle command: compute y from the resident A and x.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat while in a LOAD state.
- in_data  in  B  signed operand.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts a result.
- out_data  out  ACC_W  signed y[r], r = 0..K-1 in order.
- out_last  out  1  high with y[K-1].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the y[K-1] handshake.
- err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; in_ready, out_valid, out_last, busy, done, err = 0; all counters = 0. A/x memory contents are undefined after reset.
- States and transitions:
  - IDLE: load_matrix -> LOAD_A; load_vector -> LOAD_X; start -> COMPUTE.
  - If commands coincide in IDLE, priority is load_matrix > load_vector > start; each dropped command sets err.
  - Any command while busy is ignored and sets err.
- LOAD_A:
  - in_ready = 1; one element per in_valid&in_ready beat.
  - Beat n maps to row r = n/K, column c = n%K. It is stored in lane r%P at slot (r/P)*K + c.
  - After beat K*K-1 is accepted: -> IDLE, with in_ready low in the next cycle.
  - in_valid low stalls the load without timeout.
- LOAD_X: same handshake; beat c writes x[c], shared by all lanes. After K beats -> IDLE.
- COMPUTE:
  - For group g = 0..K/P-1, step c = 0..K-1 one per cycle.
  - Each lane l reads A[g*P+l][c] and x[c] in the same cycle.
  - Pipeline: memory read (1) -> optional product register (G) -> accumulate (1). Lane latency L = 2+G.
  - The accumulator clears on the first product of each group; the next group's issue does not overlap the previous group's drain.
  - After the last product of a group is accumulated, the P results are written to result buffer entries g*P..g*P+P-1.
  - After the last group -> OUTPUT.
  - Total compute cycles = (K/P)*(K+L) exactly.
- Arithmetic:
  - Full-precision signed B x B product, sign-extended to ACC_W; no saturation or rounding.
  - The ACC_W choice makes overflow impossible for any inputs.
- OUTPUT:
  - out_valid = 1 with out_data = y[r]; r advances only on out_valid&out_ready.
  - out_data and out_last hold stable while stalled.
  - After the y[K-1] handshake: out_valid = 0, done pulses for 1 cycle, -> IDLE.
- start before any load uses whatever the memories hold. No error is raised; the result is undefined.
- reset asserted mid-operation aborts immediately to reset values. Matrix and vector must then be reloaded.
- A and x persist across runs. Each new start recomputes from the current contents.

Test Plan:
- K=4, P=2, B=8, G=1: load A = 3·I, x = [1,2,3,4], start -> y = [3,6,9,12]; out_last with 12; done one cycle after; compute takes exactly 2*(4+3) = 14 cycles.
- Same config, A = all -128, x = all -128 -> every y = 65536 (ACC_W = 18, no wrap); A = all 127, x = all -128 -> every y = -65024.
- Matrix reuse: keep A = 3·I, load x = [-1,0,5,-7], start -> y = [-3,0,15,-21] without reloading A.
- Back-pressure: out_ready low for 5 cycles at r=1, and in_valid toggled every other cycle during LOAD_A -> outputs stay stable while stalled, no beat lost or duplicated, results unchanged.
- Command misuse: start during LOAD_X, and load_vector+start together in IDLE -> err = 1 and sticky; the load completes correctly; only load_vector takes effect.
- Reset (low) mid-COMPUTE and mid-OUTPUT -> all outputs return to 0 within the same cycle; after reloading, the next run gives correct y.

Source files
------------

// File: rtl/mvm_stream_engine.sv
// mvm_stream_engine
//   Streaming signed matrix-vector multiply, y = A*x, with A (KxK) and x (Kx1)
//   resident in on-chip memories. P MAC lanes work on one row group at a
//   time, so K rows take K/P passes over the vector.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   load_matrix  command pulse: the next K*K input beats are A, row-major
//   load_vector  command pulse: the next K input beats are x
//   start        command pulse: compute y from the resident A and x
//   in_valid     input beat valid
//   in_ready     high while in a load state
//   in_data      signed B-bit operand
//   out_valid    result beat valid
//   out_ready    consumer accepts a result
//   out_data     signed ACC_W-bit y[r], r = 0..K-1 in order
//   out_last     high together with y[K-1]
//   busy         high whenever the engine is not idle
//   done         one-cycle pulse after the y[K-1] handshake
//   err          sticky command-misuse flag, cleared only by reset
module mvm_stream_engine #(
    parameter int K     = 8,
    parameter int P     = 4,
    parameter int B     = 16,
    parameter int G     = 1,
    parameter int ACC_W = 2*B + $clog2(K)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_matrix,
    input  logic                    load_vector,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [B-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int GRPS  = K / P;
    localparam int SLOTS = GRPS * K;
    localparam int L     = 2 + G;
    localparam int CW    = $clog2(K);
    localparam int LW    = (P > 1) ? $clog2(P) : 1;
    localparam int GW    = (GRPS > 1) ? $clog2(GRPS) : 1;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TW    = $clog2(K + L);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;

    function automatic logic signed [2*B-1:0] mul_full(input logic signed [B-1:0] a,
                                                       input logic signed [B-1:0] b);
        logic signed [2*B-1:0] ae;
        logic signed [2*B-1:0] be;
        ae = (2*B)'(a);
        be = (2*B)'(b);
        return ae * be;
    endfunction

    // ACC_W leaves log2(K) guard bits, so plain sign extension can never wrap.
    function automatic logic signed [ACC_W-1:0] ext_prod(input logic signed [2*B-1:0] p);
        return ACC_W'(p);
    endfunction

    state_t state, state_d;
    logic   err_set, cmd_any, accept, issue;

    logic [CW-1:0] ld_col, out_idx;
    logic [LW-1:0] ld_lane;
    logic [GW-1:0] ld_grp, grp;
    logic [TW-1:0] cyc;
    logic [SW-1:0] wr_slot, rd_slot;

    logic signed [B-1:0]     a_mem [P][SLOTS];
    logic signed [B-1:0]     x_mem [K];
    logic signed [ACC_W-1:0] res_buf [K];

    logic signed [B-1:0]     a_p0 [P];
    logic signed [B-1:0]     x_p0;
    logic                    vld_p0, first_p0, last_p0;
    logic signed [2*B-1:0]   prod_p1 [P];
    logic                    vld_p1, first_p1, last_p1;
    logic signed [ACC_W-1:0] acc_p2 [P];
    logic                    vld_p2, last_p2;

    assign cmd_any = load_matrix | load_vector | start;
    assign accept  = in_valid & in_ready;
    assign issue   = (state == COMPUTE) && (cyc < TW'(K));
    // Row r = grp*P + lane lives in lane r%P at slot (r/P)*K + c.
    assign wr_slot = SW'(int'(ld_grp) * K + int'(ld_col));
    assign rd_slot = SW'(int'(grp) * K + int'(cyc));

    always_comb begin
        state_d   = state;
        err_set   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (load_matrix) begin
                    state_d = LOAD_A;
                    err_set = load_vector | start;
                end else if (load_vector) begin
                    state_d = LOAD_X;
                    err_set = start;
                end else if (start) begin
                    state_d = COMPUTE;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                err_set  = cmd_any;
                if (in_valid && ld_col == CW'(K-1) && ld_lane == LW'(P-1) && ld_grp == GW'(GRPS-1))
                    state_d = IDLE;
            end
            LOAD_X: begin
                in_ready = 1'b1;
                err_set  = cmd_any;
                if (in_valid && ld_col == CW'(K-1))
                    state_d = IDLE;
            end
            COMPUTE: begin
                err_set = cmd_any;
                if (cyc == TW'(K+L-1) && grp == GW'(GRPS-1))
                    state_d = OUTPUT;
            end
            OUTPUT: begin
                err_set   = cmd_any;
                out_valid = 1'b1;
                out_data  = res_buf[out_idx];
                out_last  = (out_idx == CW'(K-1));
                if (out_ready && out_idx == CW'(K-1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            err      <= 1'b0;
            done     <= 1'b0;
            ld_col   <= '0;
            ld_lane  <= '0;
            ld_grp   <= '0;
            cyc      <= '0;
            grp      <= '0;
            out_idx  <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
        end else begin
            state <= state_d;
            err   <= err | err_set;
            done  <= (state == OUTPUT) && out_ready && (out_idx == CW'(K-1));
            if (accept) begin
                ld_col <= (ld_col == CW'(K-1)) ? '0 : ld_col + 1'b1;
                if (state == LOAD_A && ld_col == CW'(K-1)) begin
                    ld_lane <= (ld_lane == LW'(P-1)) ? '0 : ld_lane + 1'b1;
                    if (ld_lane == LW'(P-1))
                        ld_grp <= (ld_grp == GW'(GRPS-1)) ? '0 : ld_grp + 1'b1;
                end
            end
            // Each group issues K reads then drains L cycles, so groups never overlap.
            if (state == COMPUTE) begin
                if (cyc == TW'(K+L-1)) begin
                    cyc <= '0;
                    grp <= (grp == GW'(GRPS-1)) ? '0 : grp + 1'b1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
            if (state == OUTPUT && out_ready)
                out_idx <= (out_idx == CW'(K-1)) ? '0 : out_idx + 1'b1;
            vld_p0   <= issue;
            first_p0 <= issue && (cyc == '0);
            last_p0  <= issue && (cyc == TW'(K-1));
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state == LOAD_A)
            a_mem[ld_lane][wr_slot] <= in_data;
        if (accept && state == LOAD_X)
            x_mem[ld_col] <= in_data;
        // ---- p0: operand read ----
        if (issue) begin
            for (int l = 0; l < P; l++)
                a_p0[l] <= a_mem[l][rd_slot];
            x_p0 <= x_mem[cyc[CW-1:0]];
        end
    end

    // ---- p1: product (registered when G = 1) ----
    if (G == 1) begin : g_prod_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_p1   <= 1'b0;
                first_p1 <= 1'b0;
                last_p1  <= 1'b0;
            end else begin
                vld_p1   <= vld_p0;
                first_p1 <= first_p0;
                last_p1  <= last_p0;
            end
        end
        always_ff @(posedge clk) begin
            for (int l = 0; l < P; l++)
                prod_p1[l] <= mul_full(a_p0[l], x_p0);
        end
    end else begin : g_prod_comb
        always_comb begin
            vld_p1   = vld_p0;
            first_p1 = first_p0;
            last_p1  = last_p0;
            for (int l = 0; l < P; l++)
                prod_p1[l] = mul_full(a_p0[l], x_p0);
        end
    end

    // ---- p2: accumulate; the first product of a group restarts the sum ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 & last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            for (int l = 0; l < P; l++)
                acc_p2[l] <= first_p1 ? ext_prod(prod_p1[l])
                                      : acc_p2[l] + ext_prod(prod_p1[l]);
        end
        // Final sums land in the result buffer on the group's last compute cycle.
        if (vld_p2 && last_p2) begin
            for (int l = 0; l < P; l++)
                res_buf[CW'(int'(grp) * P + l)] <= acc_p2[l];
        end
    end
endmodule

// File: tb/tb_mvm_stream_engine.sv
// Directed testbench for mvm_stream_engine, configured K=4, P=2, B=8, G=1.
module tb_mvm_stream_engine;
    localparam int K     = 4;
    localparam int P     = 2;
    localparam int B     = 8;
    localparam int G     = 1;
    localparam int ACC_W = 2*B + $clog2(K);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    load_matrix = 1'b0;
    logic                    load_vector = 1'b0;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [B-1:0]     in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_data;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic                    err;

    int n_cmp = 0;
    int n_bad = 0;

    int mat [K*K];
    int vec [K];
    int ex  [K];

    mvm_stream_engine #(.K(K), .P(P), .B(B), .G(G)) dut (
        .clk(clk), .reset(reset),
        .load_matrix(load_matrix), .load_vector(load_vector), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic lm, input logic lv, input logic st);
        load_matrix = lm;
        load_vector = lv;
        start       = st;
        @(posedge clk); #1;
        load_matrix = 1'b0;
        load_vector = 1'b0;
        start       = 1'b0;
    endtask

    task automatic send(input int v, input bit gap);
        int n;
        n = 0;
        in_data  = B'(v);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_mat(input int m [K*K], input bit gap);
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < K*K; i++) send(m[i], gap);
        check("load_a_in_ready_low", in_ready, 0);
        check("load_a_idle", busy, 0);
    endtask

    task automatic load_vec(input int v [K]);
        cmd(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < K; i++) send(v[i], 1'b0);
        check("load_x_in_ready_low", in_ready, 0);
    endtask

    task automatic run(input string tag, input int e [K], input bit stall, input bit chk_cyc);
        int n;
        cmd(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (chk_cyc) check({tag, "_compute_cycles"}, n, 2*(K+2+G));
        out_ready = 1'b1;
        for (int r = 0; r < K; r++) begin
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("%s_y%0d", tag, r), out_data, e[r]);
            check($sformatf("%s_last%0d", tag, r), out_last, (r == K-1) ? 1 : 0);
            if (stall && r == 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    check({tag, "_stall_data"}, out_data, e[1]);
                    check({tag, "_stall_valid"}, out_valid, 1);
                    check({tag, "_stall_last"}, out_last, 0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_valid_low"}, out_valid, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic set_3i();
        for (int i = 0; i < K*K; i++) mat[i] = (i / K == i % K) ? 3 : 0;
    endtask

    initial begin
        // Reset state, held and after release.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_released");

        // Identity-times-3 basic run with latency check.
        set_3i();
        load_mat(mat, 1'b0);
        vec = '{1, 2, 3, 4};
        load_vec(vec);
        ex = '{3, 6, 9, 12};
        run("basic", ex, 1'b0, 1'b1);

        // Extreme operands: no wrap in the 18-bit accumulator.
        for (int i = 0; i < K*K; i++) mat[i] = -128;
        load_mat(mat, 1'b0);
        vec = '{-128, -128, -128, -128};
        load_vec(vec);
        ex = '{65536, 65536, 65536, 65536};
        run("neg_neg", ex, 1'b0, 1'b1);
        for (int i = 0; i < K*K; i++) mat[i] = 127;
        load_mat(mat, 1'b0);
        ex = '{-65024, -65024, -65024, -65024};
        run("pos_neg", ex, 1'b0, 1'b0);

        // Gapped matrix load plus output back-pressure.
        set_3i();
        load_mat(mat, 1'b1);
        vec = '{-1, 0, 5, -7};
        load_vec(vec);
        ex = '{-3, 0, 15, -21};
        run("stall", ex, 1'b1, 1'b0);

        // Matrix reuse with a new vector only.
        vec = '{2, -3, 4, -5};
        load_vec(vec);
        ex = '{6, -9, 12, -15};
        run("reuse", ex, 1'b0, 1'b0);

        // Command misuse.
        check("err_before_misuse", err, 0);
        cmd(1'b0, 1'b1, 1'b0);
        send(1, 1'b0);
        cmd(1'b0, 1'b0, 1'b1);
        check("misuse_start_err", err, 1);
        check("misuse_still_loading", in_ready, 1);
        send(2, 1'b0);
        send(3, 1'b0);
        send(4, 1'b0);
        check("misuse_load_done", in_ready, 0);
        cmd(1'b0, 1'b1, 1'b1);
        check("coincide_load_x", in_ready, 1);
        check("coincide_no_compute", out_valid, 0);
        send(4, 1'b0);
        send(3, 1'b0);
        send(2, 1'b0);
        send(1, 1'b0);
        check("coincide_err_sticky", err, 1);
        ex = '{12, 9, 6, 3};
        run("after_misuse", ex, 1'b0, 1'b0);
        check("err_sticky_end", err, 1);

        // Reset mid-COMPUTE.
        cmd(1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_compute");
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        set_3i();
        load_mat(mat, 1'b0);
        vec = '{1, 2, 3, 4};
        load_vec(vec);
        ex = '{3, 6, 9, 12};
        run("post_rst_compute", ex, 1'b0, 1'b1);

        // Reset mid-OUTPUT.
        cmd(1'b0, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("mid_output_reached", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_output");
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        load_mat(mat, 1'b0);
        vec = '{-1, 0, 5, -7};
        load_vec(vec);
        ex = '{-3, 0, 15, -21};
        run("post_rst_output", ex, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
